// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared types and constants for the i2c_reg_seq register-access
// sequencer.
//   seq_state_t          - sequencer FSM states
//   seq_status_t         - command completion codes reported on `status`
//   DEFAULT_TIMEOUT_CYC  - default watchdog window between master events
package i2c_seq_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYC = 32'd200000;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_REG     = 4'd1,
    ST_WR_LOAD = 4'd2,
    ST_WR_WAIT = 4'd3,
    ST_RSTART  = 4'd4,
    ST_RD_WAIT = 4'd5,
    ST_RD_HOLD = 4'd6,
    ST_STOP    = 4'd7,
    ST_DONE    = 4'd8
  } seq_state_t;

  // Code 3 is reserved and never produced.
  typedef enum logic [1:0] {
    STS_OK      = 2'd0,
    STS_NACK    = 2'd1,
    STS_TIMEOUT = 2'd2
  } seq_status_t;

endpackage

// File: rtl/i2c_seq_wdog.sv
// i2c_seq_wdog: loadable down-counter watchdog for the sequencer.
//   clk      - system clock
//   reset    - synchronous active-low reset (counter to 0)
//   load_val - value reloaded on clear
//   clear    - reload the counter (takes priority over en)
//   en       - count down by one per cycle while nonzero
//   expired  - high while enabled and the counter has reached 0
module i2c_seq_wdog #(
  parameter int unsigned CNT_W = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clear,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_r;

  // Reload on clear, otherwise count down and saturate at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != '0)) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Gated by en so an idle sequencer never sees a stale expiry.
  assign expired = en && (cnt_r == '0);

endmodule

// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: turns one host register command into the i2c_master control
// sequence (START, address + register byte, N writes or repeated START and
// N reads, STOP), with write/read data streaming, NACK abort and watchdog.
//   cmd_*            - command request (latched on cmd_valid && cmd_ready)
//   wr_valid/ready/data, rd_valid/ready/data - data streams to/from host
//   done, status     - completion pulse and result code (held until next done)
//   m_i2c_en/start/stop, m_i2c_rw, m_slave_addr, m_tx_data - to the master
//   m_rx_data, m_tx_done, m_rx_done, m_busy, m_ack_error   - from the master
// All outputs are registered; control pulses are one cycle wide.
module i2c_reg_seq
  import i2c_seq_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned LEN_W       = $clog2(MAX_LEN + 1),
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_dev_addr,
  input  logic [7:0]       cmd_reg_addr,
  input  logic             cmd_rw,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic [1:0]       status,
  output logic             m_i2c_en,
  output logic             m_i2c_start,
  output logic             m_i2c_stop,
  output logic             m_i2c_rw,
  output logic [6:0]       m_slave_addr,
  output logic [7:0]       m_tx_data,
  input  logic [7:0]       m_rx_data,
  input  logic             m_tx_done,
  input  logic             m_rx_done,
  input  logic             m_busy,
  input  logic             m_ack_error
);

  localparam int unsigned WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  seq_state_t  state_r, state_nxt_s;
  seq_status_t status_r, status_nxt_s, result_r, result_nxt_s;
  logic [LEN_W-1:0] rem_r, rem_nxt_s, rem_dec_s, len_clamp_s;
  logic [6:0] dev_r, dev_nxt_s;
  logic [7:0] tx_data_r, tx_data_nxt_s, rd_data_r, rd_data_nxt_s;
  logic rw_r, rw_nxt_s, m_rw_r, m_rw_nxt_s;
  logic en_r, en_nxt_s, start_r, start_nxt_s, stop_r, stop_nxt_s;
  logic done_r, done_nxt_s, rd_valid_r, rd_valid_nxt_s;
  logic wr_ready_r, cmd_ready_r;
  logic abort_s, to_stop_s, wd_clear_s, wd_en_s, wd_expired_s;

  assign len_clamp_s = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
  assign rem_dec_s   = (rem_r != '0) ? (rem_r - LEN_W'(1)) : '0;

  // Watchdog restarts on every state entry and every master event; it only
  // counts while a bus transaction is in progress.
  assign wd_clear_s = (state_nxt_s != state_r) || m_tx_done || m_rx_done;
  assign wd_en_s    = (state_r != ST_IDLE) && (state_r != ST_DONE) && (state_r != ST_RSTART);

  i2c_seq_wdog #(.CNT_W(WD_W)) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .load_val (WD_W'(TIMEOUT_CYC - 1)),
    .clear    (wd_clear_s),
    .en       (wd_en_s),
    .expired  (wd_expired_s)
  );

  // Next-state and next-output logic; master events are tested before expiry.
  always_comb begin
    state_nxt_s    = state_r;
    status_nxt_s   = status_r;
    result_nxt_s   = result_r;
    rem_nxt_s      = rem_r;
    dev_nxt_s      = dev_r;
    tx_data_nxt_s  = tx_data_r;
    rd_data_nxt_s  = rd_data_r;
    rw_nxt_s       = rw_r;
    m_rw_nxt_s     = m_rw_r;
    rd_valid_nxt_s = rd_valid_r;
    en_nxt_s       = 1'b0;
    start_nxt_s    = 1'b0;
    stop_nxt_s     = 1'b0;
    done_nxt_s     = 1'b0;
    abort_s        = 1'b0;
    to_stop_s      = 1'b0;
    case (state_r)
      // DONE also accepts a command so back-to-back commands lose no cycle.
      ST_IDLE, ST_DONE: begin
        if (cmd_valid && cmd_ready_r) begin
          state_nxt_s   = ST_REG;
          dev_nxt_s     = cmd_dev_addr;
          tx_data_nxt_s = cmd_reg_addr;
          rw_nxt_s      = cmd_rw;
          rem_nxt_s     = len_clamp_s;
          m_rw_nxt_s    = 1'b0;
          result_nxt_s  = STS_OK;
          en_nxt_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REG: begin
        if (m_tx_done) begin
          if (m_ack_error) begin
            result_nxt_s = STS_NACK;
            to_stop_s    = 1'b1;
          end else if (rem_r == '0) begin
            to_stop_s = 1'b1;
          end else if (rw_r) begin
            state_nxt_s = ST_RSTART;
            m_rw_nxt_s  = 1'b1;
            start_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_WR_LOAD;
          end
        end else begin
          abort_s = wd_expired_s;
        end
      end
      ST_WR_LOAD: begin
        if (wr_valid && wr_ready_r) begin
          state_nxt_s   = ST_WR_WAIT;
          tx_data_nxt_s = wr_data;
          en_nxt_s      = 1'b1;
        end else begin
          abort_s = wd_expired_s;
        end
      end
      ST_WR_WAIT: begin
        if (m_tx_done) begin
          if (m_ack_error) begin
            result_nxt_s = STS_NACK;
            to_stop_s    = 1'b1;
          end else begin
            rem_nxt_s = rem_dec_s;
            if (rem_dec_s != '0) begin
              state_nxt_s = ST_WR_LOAD;
            end else begin
              to_stop_s = 1'b1;
            end
          end
        end else begin
          abort_s = wd_expired_s;
        end
      end
      ST_RSTART: begin
        state_nxt_s = ST_RD_WAIT;
      end
      // The master drives the ACK on reads, so m_ack_error is ignored here.
      ST_RD_WAIT: begin
        if (m_rx_done) begin
          state_nxt_s    = ST_RD_HOLD;
          rd_data_nxt_s  = m_rx_data;
          rd_valid_nxt_s = 1'b1;
        end else begin
          abort_s = wd_expired_s;
        end
      end
      ST_RD_HOLD: begin
        if (rd_ready && rd_valid_r) begin
          rd_valid_nxt_s = 1'b0;
          rem_nxt_s      = rem_dec_s;
          if (rem_dec_s != '0) begin
            state_nxt_s = ST_RD_WAIT;
            en_nxt_s    = 1'b1;
          end else begin
            to_stop_s = 1'b1;
          end
        end else begin
          abort_s = wd_expired_s;
        end
      end
      // The cycle carrying the stop pulse is skipped so the master has
      // time to react before m_busy is trusted.
      ST_STOP: begin
        if (!stop_r && !m_busy) begin
          state_nxt_s  = ST_DONE;
          done_nxt_s   = 1'b1;
          status_nxt_s = result_r;
        end else begin
          abort_s = wd_expired_s;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    if (abort_s) begin
      rd_valid_nxt_s = 1'b0;
      if (m_busy && (state_r != ST_STOP)) begin
        state_nxt_s  = ST_STOP;
        stop_nxt_s   = 1'b1;
        result_nxt_s = STS_TIMEOUT;
      end else begin
        state_nxt_s  = ST_DONE;
        done_nxt_s   = 1'b1;
        status_nxt_s = STS_TIMEOUT;
      end
    end else if (to_stop_s) begin
      state_nxt_s = ST_STOP;
      stop_nxt_s  = 1'b1;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      status_r    <= STS_OK;
      result_r    <= STS_OK;
      rem_r       <= '0;
      dev_r       <= 7'd0;
      tx_data_r   <= 8'd0;
      rd_data_r   <= 8'd0;
      rw_r        <= 1'b0;
      m_rw_r      <= 1'b0;
      rd_valid_r  <= 1'b0;
      en_r        <= 1'b0;
      start_r     <= 1'b0;
      stop_r      <= 1'b0;
      done_r      <= 1'b0;
      wr_ready_r  <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      status_r    <= status_nxt_s;
      result_r    <= result_nxt_s;
      rem_r       <= rem_nxt_s;
      dev_r       <= dev_nxt_s;
      tx_data_r   <= tx_data_nxt_s;
      rd_data_r   <= rd_data_nxt_s;
      rw_r        <= rw_nxt_s;
      m_rw_r      <= m_rw_nxt_s;
      rd_valid_r  <= rd_valid_nxt_s;
      en_r        <= en_nxt_s;
      start_r     <= start_nxt_s;
      stop_r      <= stop_nxt_s;
      done_r      <= done_nxt_s;
      wr_ready_r  <= (state_nxt_s == ST_WR_LOAD);
      cmd_ready_r <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_DONE);
    end
  end

  assign cmd_ready    = cmd_ready_r;
  assign wr_ready     = wr_ready_r;
  assign rd_valid     = rd_valid_r;
  assign rd_data      = rd_data_r;
  assign done         = done_r;
  assign status       = status_r;
  assign m_i2c_en     = en_r;
  assign m_i2c_start  = start_r;
  assign m_i2c_stop   = stop_r;
  assign m_i2c_rw     = m_rw_r;
  assign m_slave_addr = dev_r;
  assign m_tx_data    = tx_data_r;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb_i2c_reg_seq: directed self-checking bench for i2c_reg_seq with a small
// behavioural i2c_master model (fixed 3-cycle byte latency, read data 0xA5).
module tb_i2c_reg_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
  logic [6:0] cmd_dev_addr = 7'd0;
  logic [7:0] cmd_reg_addr = 8'd0;
  logic [4:0] cmd_len = 5'd0;
  logic       wr_valid = 1'b0, wr_ready;
  logic [7:0] wr_data = 8'd0;
  logic       rd_valid, rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       done;
  logic [1:0] status;
  logic       m_i2c_en, m_i2c_start, m_i2c_stop, m_i2c_rw;
  logic [6:0] m_slave_addr;
  logic [7:0] m_tx_data;
  logic [7:0] m_rx_data = 8'd0;
  logic       m_tx_done = 1'b0, m_rx_done = 1'b0, m_busy = 1'b0, m_ack_error = 1'b0;

  int checks = 0;
  int errors = 0;

  // master model state
  logic       nack_mode = 1'b0;
  int         pend = 0, stop_pend = 0;
  logic       pend_rd = 1'b0;
  int         en_cnt = 0, start_cnt = 0, stop_cnt = 0, tx_n = 0;
  logic [7:0] tx_log [0:63];
  int         overlap_cnt = 0, long_cnt = 0;
  logic       prev_en = 1'b0, prev_start = 1'b0, prev_stop = 1'b0;

  i2c_reg_seq #(.MAX_LEN(16), .LEN_W(5), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev_addr(cmd_dev_addr),
    .cmd_reg_addr(cmd_reg_addr), .cmd_rw(cmd_rw), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .status(status),
    .m_i2c_en(m_i2c_en), .m_i2c_start(m_i2c_start), .m_i2c_stop(m_i2c_stop),
    .m_i2c_rw(m_i2c_rw), .m_slave_addr(m_slave_addr), .m_tx_data(m_tx_data),
    .m_rx_data(m_rx_data), .m_tx_done(m_tx_done), .m_rx_done(m_rx_done),
    .m_busy(m_busy), .m_ack_error(m_ack_error)
  );

  always #5 clk = ~clk;

  // Behavioural master: each en/start finishes a byte 3 cycles later; stop
  // releases busy 3 cycles later.
  always @(posedge clk) begin
    if (!reset) begin
      m_tx_done <= 1'b0; m_rx_done <= 1'b0; m_ack_error <= 1'b0;
      m_busy <= 1'b0; pend <= 0; stop_pend <= 0; m_rx_data <= 8'd0;
    end else begin
      m_tx_done <= 1'b0; m_rx_done <= 1'b0; m_ack_error <= 1'b0;
      if (m_i2c_en || m_i2c_start) begin
        m_busy  <= 1'b1;
        pend    <= 3;
        pend_rd <= m_i2c_start | m_i2c_rw;
        if (m_i2c_en) en_cnt <= en_cnt + 1;
        else start_cnt <= start_cnt + 1;
        if (m_i2c_en && !m_i2c_rw) begin
          tx_log[tx_n % 64] <= m_tx_data;
          tx_n <= tx_n + 1;
        end
      end else if (pend != 0) begin
        pend <= pend - 1;
        if (pend == 1) begin
          if (pend_rd) begin
            m_rx_done <= 1'b1; m_rx_data <= 8'hA5;
          end else begin
            m_tx_done <= 1'b1; m_ack_error <= nack_mode;
          end
        end
      end
      if (m_i2c_stop) begin
        stop_cnt  <= stop_cnt + 1;
        stop_pend <= 3;
      end else if (stop_pend != 0) begin
        stop_pend <= stop_pend - 1;
        if (stop_pend == 1) m_busy <= 1'b0;
      end
    end
  end

  // Pulse-shape monitor: overlapping or stretched control pulses.
  always @(negedge clk) begin
    if ((int'(m_i2c_en) + int'(m_i2c_start) + int'(m_i2c_stop)) > 1) overlap_cnt <= overlap_cnt + 1;
    if ((m_i2c_en && prev_en) || (m_i2c_start && prev_start) || (m_i2c_stop && prev_stop))
      long_cnt <= long_cnt + 1;
    prev_en <= m_i2c_en; prev_start <= m_i2c_start; prev_stop <= m_i2c_stop;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic send_cmd(input logic [6:0] dev, input logic [7:0] ra, input logic rw,
                          input logic [4:0] len, output logic en_seen);
    for (int k = 0; k < 50 && cmd_ready !== 1'b1; k++) @(negedge clk);
    cmd_dev_addr = dev; cmd_reg_addr = ra; cmd_rw = rw; cmd_len = len; cmd_valid = 1'b1;
    @(posedge clk); #1;
    en_seen = m_i2c_en;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ok, output logic en_seen,
                         output logic [7:0] txd);
    ok = 1'b0; en_seen = 1'b0; txd = 8'd0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (wr_ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) begin
      wr_data = d; wr_valid = 1'b1;
      @(posedge clk); #1;
      en_seen = m_i2c_en; txd = m_tx_data;
      @(negedge clk);
      wr_valid = 1'b0;
    end
  endtask

  task automatic wait_rd_valid(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (rd_valid === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic rd_byte(output logic ok, output logic [7:0] d, output logic dropped);
    d = 8'd0; dropped = 1'b0;
    wait_rd_valid(ok);
    if (ok) begin
      d = rd_data; rd_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      dropped = (rd_valid === 1'b0);
      rd_ready = 1'b0;
    end
  endtask

  task automatic wait_done(output logic got, output logic [1:0] st, output logic saw_wr);
    got = 1'b0; st = 2'd3; saw_wr = 1'b0;
    for (int k = 0; k < 1000 && !got; k++) begin
      if (wr_ready === 1'b1) saw_wr = 1'b1;
      if (done === 1'b1) begin
        got = 1'b1; st = status;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [32:0] obs;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    obs = {cmd_ready, wr_ready, rd_valid, done, status, m_i2c_en, m_i2c_start, m_i2c_stop,
           m_i2c_rw, m_slave_addr, m_tx_data, rd_data};
    checks++;
    if (obs !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL reset_values got %h want %h", obs, {1'b1, 32'h0});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write2();
    int en0 = en_cnt, st0 = start_cnt, sp0 = stop_cnt, tx0 = tx_n;
    logic en_seen, ok, got, saw_wr;
    logic [7:0] txd, exp_b;
    logic [1:0] st;
    send_cmd(7'h55, 8'h10, 1'b0, 5'd2, en_seen);
    checks++;
    if (en_seen !== 1'b1) begin errors++; $display("FAIL wr2_cmd_to_en got %b want 1", en_seen); end
    checks++;
    if (m_slave_addr !== 7'h55) begin errors++; $display("FAIL wr2_slave_addr got %h want 55", m_slave_addr); end
    for (int i = 0; i < 2; i++) begin
      exp_b = (i == 0) ? 8'h42 : 8'h43;
      wr_byte(exp_b, ok, en_seen, txd);
      checks++;
      if ({ok, en_seen, txd} !== {1'b1, 1'b1, exp_b}) begin
        errors++; $display("FAIL wr2_data%0d got ok=%b en=%b tx=%h want 1 1 %h", i, ok, en_seen, txd, exp_b);
      end
    end
    wait_done(got, st, saw_wr);
    checks++;
    if ({got, st} !== {1'b1, 2'd0}) begin errors++; $display("FAIL wr2_done got %b/%0d want 1/0", got, st); end
    checks++;
    if ({en_cnt - en0, start_cnt - st0, stop_cnt - sp0, tx_n - tx0} !== {32'd3, 32'd0, 32'd1, 32'd3}) begin
      errors++; $display("FAIL wr2_counts en=%0d start=%0d stop=%0d tx=%0d want 3 0 1 3",
                         en_cnt - en0, start_cnt - st0, stop_cnt - sp0, tx_n - tx0);
    end
    checks++;
    if ({tx_log[tx0 % 64], tx_log[(tx0 + 1) % 64], tx_log[(tx0 + 2) % 64]} !== 24'h104243) begin
      errors++; $display("FAIL wr2_tx_bytes got %h %h %h want 10 42 43",
                         tx_log[tx0 % 64], tx_log[(tx0 + 1) % 64], tx_log[(tx0 + 2) % 64]);
    end
  endtask

  task automatic test_read3();
    int en0 = en_cnt, st0 = start_cnt, sp0 = stop_cnt, tx0 = tx_n;
    logic en_seen, ok, got, saw_wr, dropped;
    logic [7:0] d;
    logic [1:0] st;
    send_cmd(7'h55, 8'h10, 1'b1, 5'd3, en_seen);
    for (int i = 0; i < 3; i++) begin
      rd_byte(ok, d, dropped);
      checks++;
      if ({ok, d, dropped} !== {1'b1, 8'hA5, 1'b1}) begin
        errors++; $display("FAIL rd3_byte%0d got ok=%b d=%h drop=%b want 1 a5 1", i, ok, d, dropped);
      end
    end
    wait_done(got, st, saw_wr);
    checks++;
    if ({got, st} !== {1'b1, 2'd0}) begin errors++; $display("FAIL rd3_done got %b/%0d want 1/0", got, st); end
    checks++;
    if ({en_cnt - en0, start_cnt - st0, stop_cnt - sp0, tx_n - tx0} !== {32'd3, 32'd1, 32'd1, 32'd1}) begin
      errors++; $display("FAIL rd3_counts en=%0d start=%0d stop=%0d tx=%0d want 3 1 1 1",
                         en_cnt - en0, start_cnt - st0, stop_cnt - sp0, tx_n - tx0);
    end
    checks++;
    if (tx_log[tx0 % 64] !== 8'h10) begin errors++; $display("FAIL rd3_reg_byte got %h want 10", tx_log[tx0 % 64]); end
  endtask

  task automatic test_nack();
    int en0 = en_cnt, sp0 = stop_cnt;
    logic en_seen, got, saw_wr;
    logic [1:0] st;
    nack_mode = 1'b1;
    send_cmd(7'h21, 8'h05, 1'b0, 5'd2, en_seen);
    wait_done(got, st, saw_wr);
    nack_mode = 1'b0;
    checks++;
    if ({got, st} !== {1'b1, 2'd1}) begin errors++; $display("FAIL nack_status got %b/%0d want 1/1", got, st); end
    checks++;
    if (saw_wr !== 1'b0) begin errors++; $display("FAIL nack_wr_ready got %b want 0", saw_wr); end
    checks++;
    if ({en_cnt - en0, stop_cnt - sp0} !== {32'd1, 32'd1}) begin
      errors++; $display("FAIL nack_counts en=%0d stop=%0d want 1 1", en_cnt - en0, stop_cnt - sp0);
    end
  endtask

  task automatic test_timeout();
    logic en_seen, ok, got, saw_wr;
    logic [1:0] st;
    int k;
    send_cmd(7'h33, 8'h20, 1'b1, 5'd2, en_seen);
    wait_rd_valid(ok);
    k = 0;
    while (ok && m_i2c_stop !== 1'b1 && k < 300) begin
      @(negedge clk); k++;
    end
    checks++;
    if (k != 100) begin errors++; $display("FAIL timeout_latency got %0d want 100", k); end
    wait_done(got, st, saw_wr);
    checks++;
    if ({got, st, rd_valid} !== {1'b1, 2'd2, 1'b0}) begin
      errors++; $display("FAIL timeout_status got %b/%0d rd_valid=%b want 1/2 0", got, st, rd_valid);
    end
  endtask

  task automatic test_back_to_back();
    int en0 = en_cnt, sp0 = stop_cnt, tx0 = tx_n;
    logic en_seen, ok, got, saw_wr, dropped;
    logic [7:0] d;
    logic [1:0] st;
    send_cmd(7'h44, 8'h33, 1'b0, 5'd0, en_seen);
    wait_done(got, st, saw_wr);
    checks++;
    if ({got, st, cmd_ready} !== {1'b1, 2'd0, 1'b1}) begin
      errors++; $display("FAIL ptr_done got %b/%0d ready=%b want 1/0 1", got, st, cmd_ready);
    end
    checks++;
    if ({en_cnt - en0, stop_cnt - sp0, tx_n - tx0, tx_log[tx0 % 64]} !== {32'd1, 32'd1, 32'd1, 8'h33}) begin
      errors++; $display("FAIL ptr_counts en=%0d stop=%0d tx=%0d byte=%h want 1 1 1 33",
                         en_cnt - en0, stop_cnt - sp0, tx_n - tx0, tx_log[tx0 % 64]);
    end
    // Issued in the same cycle done/cmd_ready are observed.
    cmd_dev_addr = 7'h44; cmd_reg_addr = 8'h44; cmd_rw = 1'b1; cmd_len = 5'd1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({m_i2c_en, m_tx_data} !== {1'b1, 8'h44}) begin
      errors++; $display("FAIL b2b_accept got en=%b tx=%h want 1 44", m_i2c_en, m_tx_data);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rd_byte(ok, d, dropped);
    wait_done(got, st, saw_wr);
    checks++;
    if ({ok, d, got, st} !== {1'b1, 8'hA5, 1'b1, 2'd0}) begin
      errors++; $display("FAIL b2b_read got ok=%b d=%h done=%b st=%0d want 1 a5 1 0", ok, d, got, st);
    end
  endtask

  task automatic test_clamp();
    int en0 = en_cnt, n = 0;
    logic en_seen, got;
    logic [1:0] st;
    got = 1'b0; st = 2'd3;
    send_cmd(7'h12, 8'h00, 1'b0, 5'd20, en_seen);
    for (int k = 0; k < 3000 && !got; k++) begin
      if (done === 1'b1) begin
        got = 1'b1; st = status; wr_valid = 1'b0;
      end else begin
        wr_valid = wr_ready; wr_data = 8'(n);
        if (wr_ready === 1'b1) n++;
        @(negedge clk);
      end
    end
    wr_valid = 1'b0;
    checks++;
    if ({got, st, n, en_cnt - en0} !== {1'b1, 2'd0, 32'd16, 32'd17}) begin
      errors++; $display("FAIL clamp got done=%b st=%0d bytes=%0d en=%0d want 1 0 16 17", got, st, n, en_cnt - en0);
    end
  endtask

  task automatic test_reset_mid_read();
    logic en_seen, seen;
    logic [32:0] obs;
    seen = 1'b0;
    send_cmd(7'h5A, 8'h01, 1'b1, 5'd2, en_seen);
    for (int k = 0; k < 100 && !seen; k++) begin
      if (m_i2c_start === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL midrst_start got %b want 1", seen); end
    reset = 1'b0;
    @(posedge clk); #1;
    obs = {cmd_ready, wr_ready, rd_valid, done, status, m_i2c_en, m_i2c_start, m_i2c_stop,
           m_i2c_rw, m_slave_addr, m_tx_data, rd_data};
    checks++;
    if (obs !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL midrst_values got %h want %h", obs, {1'b1, 32'h0});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pulses();
    checks++;
    if ({overlap_cnt, long_cnt} !== {32'd0, 32'd0}) begin
      errors++; $display("FAIL pulse_shape overlap=%0d long=%0d want 0 0", overlap_cnt, long_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write2();
    test_read3();
    test_nack();
    test_timeout();
    test_back_to_back();
    test_clamp();
    test_reset_mid_read();
    test_pulses();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
